// File: rtl/dbus_ctrl.sv
// ============================================================================
// dbus_ctrl : single-request data-bus controller with a req/ack handshake
// Optional DBUS_TIMEOUT_EN aborts a WAIT that runs too long.   Revision 1.0
// ============================================================================
`default_nettype none

module dbus_ctrl #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              l_or_s_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              bus_req_o,
  output logic [DATA_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic              bus_we_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic [DATA_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic                bus_we_q, bus_we_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                w_misaligned;
  logic                w_timeout;

  assign w_misaligned = (addr_i[1:0] != 2'b00);

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter value is the number of ack-less WAIT cycles already seen;
  // the cycle that would make it reach the limit is the one that aborts.
  assign w_timeout = (state_q == WAIT) && !bus_ack_i &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != WAIT) begin
      cnt_d = '0;
    end else if (!bus_ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = bus_we_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (w_misaligned) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = WAIT;
            bus_req_d   = 1'b1;
            bus_addr_d  = addr_i;
            bus_wdata_d = wdata_i;
            bus_we_d    = ~l_or_s_i;
          end
        end
      end

      WAIT: begin
        // An ack in the same cycle as timeout expiry takes precedence.
        if (bus_ack_i) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          if (bus_err_i) begin
            err_d = 1'b1;
          end else if (!bus_we_q) begin
            rdata_d = bus_rdata_i;
          end
        end else if (w_timeout) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Combinational so the accept cycle itself already holds the pipeline.
  assign stall_o     = (state_q == WAIT) || ((state_q == IDLE) && req_valid_i);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign bus_req_o   = bus_req_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_we_o    = bus_we_q;

endmodule

`default_nettype wire

// File: tb/tb_dbus_ctrl.sv
// ============================================================================
// tb_dbus_ctrl : vector-table and directed-sequence bench for dbus_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        l_or_s_i;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_we_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dbus_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .l_or_s_i    (l_or_s_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .bus_req_o   (bus_req_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_we_o    (bus_we_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .bus_err_i   (bus_err_i)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ls;
    logic        ack;
    logic [31:0] brdata;
    logic        berr;
    logic        e_stall;
    logic        e_done;
    logic        e_err;
    logic [31:0] e_rdata;
    logic        e_breq;
    logic        e_we;
    logic [31:0] e_baddr;
    logic [31:0] e_bwdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic ls, input logic ack, input logic [31:0] brdata,
                     input logic berr, input logic e_stall, input logic e_done,
                     input logic e_err, input logic [31:0] e_rdata, input logic e_breq,
                     input logic e_we, input logic [31:0] e_baddr,
                     input logic [31:0] e_bwdata);
    vec_t v;
    v.req = req; v.addr = addr; v.wdata = wdata; v.ls = ls;
    v.ack = ack; v.brdata = brdata; v.berr = berr;
    v.e_stall = e_stall; v.e_done = e_done; v.e_err = e_err; v.e_rdata = e_rdata;
    v.e_breq = e_breq; v.e_we = e_we; v.e_baddr = e_baddr; v.e_bwdata = e_bwdata;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] STW  = 32'h1234_5678;
  localparam logic [31:0] BAD  = 32'h0BAD_F00D;

  initial begin
    // Inputs: req addr wdata ls ack brdata berr | expected: stall done err rdata breq we baddr bwdata
    add(0, 32'h0,    32'h0, 0, 0, 32'h0,         0,  0, 0, 0, 32'h0, 0, 0, 32'h0,    32'h0);
    // aligned load, ack in the first WAIT cycle
    add(1, 32'h1004, 32'h0, 1, 0, 32'h0,         0,  1, 0, 0, 32'h0, 0, 0, 32'h0,    32'h0);
    add(1, 32'h1004, 32'h0, 1, 1, BEEF,          0,  1, 0, 0, 32'h0, 1, 0, 32'h1004, 32'h0);
    add(1, 32'h1004, 32'h0, 1, 0, 32'h0,         0,  0, 1, 0, BEEF,  0, 0, 32'h1004, 32'h0);
    add(0, 32'h0,    32'h0, 0, 0, 32'h0,         0,  0, 0, 0, BEEF,  0, 0, 32'h1004, 32'h0);
    // store, ack on the third WAIT cycle; read data on the bus must be ignored
    add(1, 32'h2000, STW,   0, 0, 32'h0,         0,  1, 0, 0, BEEF,  0, 0, 32'h1004, 32'h0);
    add(1, 32'h2000, STW,   0, 0, 32'hAAAA_5555, 0,  1, 0, 0, BEEF,  1, 1, 32'h2000, STW);
    add(1, 32'h2000, STW,   0, 0, 32'hAAAA_5555, 0,  1, 0, 0, BEEF,  1, 1, 32'h2000, STW);
    add(1, 32'h2000, STW,   0, 1, 32'hAAAA_5555, 0,  1, 0, 0, BEEF,  1, 1, 32'h2000, STW);
    add(1, 32'h2000, STW,   0, 0, 32'h0,         0,  0, 1, 0, BEEF,  0, 1, 32'h2000, STW);
    // misaligned load accepted back-to-back
    add(1, 32'h1002, 32'h0, 1, 0, 32'h0,         0,  1, 0, 0, BEEF,  0, 1, 32'h2000, STW);
    add(1, 32'h1002, 32'h0, 1, 0, 32'h0,         0,  0, 1, 1, BEEF,  0, 1, 32'h2000, STW);
    add(0, 32'h0,    32'h0, 0, 0, 32'h0,         0,  0, 0, 0, BEEF,  0, 1, 32'h2000, STW);
    // load answered with a bus error
    add(1, 32'h3000, BAD,   1, 0, 32'h0,         0,  1, 0, 0, BEEF,  0, 1, 32'h2000, STW);
    add(1, 32'h3000, BAD,   1, 1, 32'hFFFF_FFFF, 1,  1, 0, 0, BEEF,  1, 0, 32'h3000, BAD);
    add(1, 32'h3000, BAD,   1, 0, 32'h0,         0,  0, 1, 1, BEEF,  0, 0, 32'h3000, BAD);
    // stray ack while idle has no effect
    add(0, 32'h0,    32'h0, 0, 1, 32'h5555_5555, 1,  0, 0, 0, BEEF,  0, 0, 32'h3000, BAD);
    add(0, 32'h0,    32'h0, 0, 0, 32'h0,         0,  0, 0, 0, BEEF,  0, 0, 32'h3000, BAD);
    // misaligned store
    add(1, 32'h2003, 32'h1, 0, 0, 32'h0,         0,  1, 0, 0, BEEF,  0, 0, 32'h3000, BAD);
    add(1, 32'h2003, 32'h1, 0, 0, 32'h0,         0,  0, 1, 1, BEEF,  0, 0, 32'h3000, BAD);
    add(0, 32'h0,    32'h0, 0, 0, 32'h0,         0,  0, 0, 0, BEEF,  0, 0, 32'h3000, BAD);

    rst = 1'b1; req_valid_i = 1'b0; addr_i = '0; wdata_i = '0; l_or_s_i = 1'b0;
    bus_ack_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    foreach (vecs[i]) begin
      req_valid_i = vecs[i].req;
      addr_i      = vecs[i].addr;
      wdata_i     = vecs[i].wdata;
      l_or_s_i    = vecs[i].ls;
      bus_ack_i   = vecs[i].ack;
      bus_rdata_i = vecs[i].brdata;
      bus_err_i   = vecs[i].berr;
      @(negedge clk);
      chk($sformatf("v%0d stall", i),  stall_o,     vecs[i].e_stall);
      chk($sformatf("v%0d done", i),   done_o,      vecs[i].e_done);
      chk($sformatf("v%0d err", i),    err_o,       vecs[i].e_err);
      chk($sformatf("v%0d rdata", i),  rdata_o,     vecs[i].e_rdata);
      chk($sformatf("v%0d bus_req", i), bus_req_o,  vecs[i].e_breq);
      chk($sformatf("v%0d bus_we", i), bus_we_o,    vecs[i].e_we);
      chk($sformatf("v%0d bus_addr", i), bus_addr_o, vecs[i].e_baddr);
      chk($sformatf("v%0d bus_wdata", i), bus_wdata_o, vecs[i].e_bwdata);
      tick();
    end
    bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;

    // Load that is never acknowledged
    req_valid_i = 1'b1; addr_i = 32'h5000; wdata_i = 32'h0; l_or_s_i = 1'b1;
    @(negedge clk);
    chk("noack accept stall", stall_o, 1'b1);
    tick();
`ifdef DBUS_TIMEOUT_EN
    begin
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!bus_req_o) break;
        n++;
        tick();
      end
      chk("timeout wait cycles", 32'(n), 32'd16);
      chk("timeout done", done_o, 1'b1);
      chk("timeout err", err_o, 1'b1);
      chk("timeout rdata", rdata_o, BEEF);
      tick();
      req_valid_i = 1'b0;
    end
`else
    begin
      logic seen_done;
      seen_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (done_o) seen_done = 1'b1;
        tick();
      end
      @(negedge clk);
      chk("noack bus_req held", bus_req_o, 1'b1);
      chk("noack stall held", stall_o, 1'b1);
      chk("noack no done", seen_done, 1'b0);
      tick();
      bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
      tick();
      bus_ack_i = 1'b0; bus_rdata_i = '0;
      @(negedge clk);
      chk("late ack done", done_o, 1'b1);
      chk("late ack err", err_o, 1'b0);
      chk("late ack rdata", rdata_o, 32'hCAFE_F00D);
      tick();
      req_valid_i = 1'b0;
    end
`endif
    tick();

    // Reset pulse in the middle of WAIT
    req_valid_i = 1'b1; addr_i = 32'h4000; wdata_i = 32'h77; l_or_s_i = 1'b1;
    tick();
    @(negedge clk);
    chk("rst-wait bus_req before", bus_req_o, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst-wait bus_req", bus_req_o, 1'b0);
    chk("rst-wait stall idle", stall_o, 1'b0);
    chk("rst-wait rdata", rdata_o, 32'h0);
    chk("rst-wait done", done_o, 1'b0);
    chk("rst-wait bus_addr", bus_addr_o, 32'h0);
    req_valid_i = 1'b1;
    #1;
    chk("rst-wait stall follows req", stall_o, 1'b1);
    req_valid_i = 1'b0;
    tick();
    @(negedge clk);
    chk("rst-wait no late done", done_o, 1'b0);
    chk("rst-wait still idle", bus_req_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
